// File: rtl/cy_stream_source.sv
// rtl/cy_stream_source.sv - valid/ready burst source with incrementing payload and LFSR-gated gaps
module cy_stream_source #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [15:0]   i_len,
    input  logic [DW-1:0] i_seed,
    input  logic          i_gap_en,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    state_t        state, state_nxt;
    logic [15:0]   rem, rem_nxt, rem_after;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [15:0]   count_nxt;
    logic [DW-1:0] data_nxt;
    logic          valid_nxt, done_nxt;
    logic          xfer, gate, fb;

    assign xfer      = o_valid & i_ready;
    assign gate      = ~i_gap_en | lfsr[0];
    assign rem_after = rem - {15'd0, xfer};
    // Fibonacci feedback for x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign fb        = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign o_busy    = (state == RUN);

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        lfsr_nxt  = lfsr;
        count_nxt = o_count;
        data_nxt  = o_data;
        valid_nxt = o_valid;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (i_start) begin
                    count_nxt = 16'd0;
                    if (i_len == 16'd0) begin
                        done_nxt = 1'b1;
                    end else begin
                        rem_nxt   = i_len;
                        data_nxt  = i_seed;
                        lfsr_nxt  = LFSR_INIT;
                        valid_nxt = ~i_gap_en | LFSR_INIT[0];
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                lfsr_nxt = {fb, lfsr[15:1]};
                if (xfer) begin
                    data_nxt  = o_data + DW'(1);
                    count_nxt = o_count + 16'd1;
                    rem_nxt   = rem_after;
                end
                if (xfer && rem_after == 16'd0) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    // A presented beat is held regardless of the gate
                    valid_nxt = (o_valid & ~i_ready) | ((rem_after != 16'd0) & gate);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            rem     <= 16'd0;
            lfsr    <= LFSR_INIT;
            o_count <= 16'd0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            lfsr    <= lfsr_nxt;
            o_count <= count_nxt;
            o_data  <= data_nxt;
            o_valid <= valid_nxt;
            o_done  <= done_nxt;
        end
    end

endmodule
